// File: rtl/mult16_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per clock, fixed WIDTH+2 cycle turnaround.
// Optional macro MULT16_HI_RESULT_EN adds the registered upper product half on port ResultHi.
module mult16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Ovf
`ifdef MULT16_HI_RESULT_EN
  ,output logic [WIDTH-1:0] ResultHi
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
  logic [WIDTH-1:0]     mplr;
  logic [CW-1:0]        cnt;
  logic                 load, step, fin;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        step = 1'b1;
        if (cnt == '0) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Final step's addition is folded into the captured result on the same edge.
  assign acc_nxt = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      Result <= '0;
      Ovf    <= 1'b0;
`ifdef MULT16_HI_RESULT_EN
      ResultHi <= '0;
`endif
    end else begin
      if (load) begin
        mcand <= {{WIDTH{1'b0}}, A};
        mplr  <= B;
        acc   <= '0;
        cnt   <= CW'(WIDTH - 1);
      end else if (step) begin
        acc   <= acc_nxt;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (fin) begin
        Result <= acc_nxt[WIDTH-1:0];
        Ovf    <= |acc_nxt[2*WIDTH-1:WIDTH];
`ifdef MULT16_HI_RESULT_EN
        ResultHi <= acc_nxt[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq: directed scenarios plus randomized operands against a plain A*B model.
module tb_mult16_seq;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] A, B;
  logic        Busy, Done, Ovf;
  logic [15:0] Result;
`ifdef MULT16_HI_RESULT_EN
  logic [15:0] ResultHi;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mult16_seq #(.WIDTH(16)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Ovf    (Ovf)
`ifdef MULT16_HI_RESULT_EN
    ,.ResultHi (ResultHi)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one operation (accepting edge = edge 0) and observes Busy/Done after edges 0..nedges.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int nedges,
                        output int done_edge, output int done_cnt, output logic [31:0] busy_bits);
    @(negedge CLK);
    A = a; B = b; Start = 1'b1;
    busy_bits = '0; done_edge = -1; done_cnt = 0;
    for (int k = 0; k <= nedges; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        Start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
      end
      busy_bits[k] = Busy;
      if (Done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
    end
  endtask

  task automatic test_reset();
    int de, dc;
    logic [31:0] bb;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
    #1;
    chk_cnt++; if ({Busy, Done, Ovf, Result} !== 19'd0) $display("FAIL por_outputs: got %h expected 0", {Busy, Done, Ovf, Result}); else pass_cnt++;
    #12 Reset = 1'b0;
    run_op(16'h1234, 16'h0002, 18, de, dc, bb);
    chk_cnt++; if (Result !== 16'h2468) $display("FAIL reset_preop_result: got %h expected 2468", Result); else pass_cnt++;
    // second op interrupted mid-run by a reset between clock edges
    @(negedge CLK); A = 16'h1234; B = 16'h0002; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    repeat (4) @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk_cnt++; if ({Busy, Done} !== 2'b00) $display("FAIL reset_async_busy_done: got %b expected 00", {Busy, Done}); else pass_cnt++;
    chk_cnt++; if ({Ovf, Result} !== 17'd0) $display("FAIL reset_async_result: got %h expected 0", {Ovf, Result}); else pass_cnt++;
`ifdef MULT16_HI_RESULT_EN
    chk_cnt++; if (ResultHi !== 16'h0) $display("FAIL reset_async_hi: got %h expected 0", ResultHi); else pass_cnt++;
`endif
    @(negedge CLK); Reset = 1'b0;
  endtask

  task automatic test_basic();
    int de, dc;
    logic [31:0] bb;
    run_op(16'd3, 16'd5, 18, de, dc, bb);
    chk_cnt++; if (bb !== 32'h0001FFFF) $display("FAIL basic_busy_trace: got %h expected 0001ffff", bb); else pass_cnt++;
    chk_cnt++; if (de !== 16 || dc !== 1) $display("FAIL basic_done_timing: got edge %0d count %0d expected edge 16 count 1", de, dc); else pass_cnt++;
    chk_cnt++; if ({Ovf, Result} !== {1'b0, 16'h000F}) $display("FAIL basic_result: got %b/%h expected 0/000f", Ovf, Result); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int de, dc;
    logic [31:0] bb;
    run_op(16'h0100, 16'h0100, 18, de, dc, bb);
    chk_cnt++; if ({Ovf, Result} !== {1'b1, 16'h0000}) $display("FAIL ovf_result: got %b/%h expected 1/0000", Ovf, Result); else pass_cnt++;
`ifdef MULT16_HI_RESULT_EN
    chk_cnt++; if (ResultHi !== 16'h0001) $display("FAIL ovf_hi: got %h expected 0001", ResultHi); else pass_cnt++;
`endif
    run_op(16'hFFFF, 16'hFFFF, 18, de, dc, bb);
    chk_cnt++; if ({Ovf, Result} !== {1'b1, 16'h0001}) $display("FAIL max_result: got %b/%h expected 1/0001", Ovf, Result); else pass_cnt++;
`ifdef MULT16_HI_RESULT_EN
    chk_cnt++; if (ResultHi !== 16'hFFFE) $display("FAIL max_hi: got %h expected fffe", ResultHi); else pass_cnt++;
`endif
    run_op(16'h0000, 16'hBEEF, 18, de, dc, bb);
    chk_cnt++; if (de !== 16 || {Ovf, Result} !== 17'd0) $display("FAIL zero_operand: got edge %0d %b/%h expected edge 16 0/0000", de, Ovf, Result); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int de = -1, dc = 0;
    @(negedge CLK); A = 16'd7; B = 16'd6; Start = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 0) Start = 1'b0;
      if (k == 3) begin Start = 1'b1; A = 16'd2; B = 16'd2; end
      if (k == 4) Start = 1'b0;
      if (Done) begin dc++; if (de < 0) de = k; end
    end
    chk_cnt++; if (de !== 16 || dc !== 1) $display("FAIL ignore_done: got edge %0d count %0d expected edge 16 count 1", de, dc); else pass_cnt++;
    chk_cnt++; if (Result !== 16'h002A || Busy !== 1'b0) $display("FAIL ignore_result: got %h busy %b expected 002a busy 0", Result, Busy); else pass_cnt++;
  endtask

  task automatic test_abort();
    int de, dc = 0;
    logic [31:0] bb;
    @(negedge CLK); A = 16'd9; B = 16'd9; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    repeat (7) @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (Done) dc++;
    end
    chk_cnt++; if (dc !== 0 || Result !== 16'h0 || Busy !== 1'b0) $display("FAIL abort_quiet: got done %0d result %h busy %b expected 0 0000 0", dc, Result, Busy); else pass_cnt++;
    run_op(16'd4, 16'd4, 18, de, dc, bb);
    chk_cnt++; if (de !== 16 || Result !== 16'h0010) $display("FAIL abort_recover: got edge %0d result %h expected edge 16 0010", de, Result); else pass_cnt++;
  endtask

  task automatic test_random();
    int de, dc;
    logic [31:0] bb, prod;
    logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 5) a = '0;
      if (i == 9) b = '0;
      if (i == 13) b = 16'h0001;
      prod = 32'(a) * 32'(b);
      run_op(a, b, 18, de, dc, bb);
      chk_cnt++;
      if (de !== 16 || dc !== 1 || Result !== prod[15:0] || Ovf !== (prod[31:16] != 16'h0))
        $display("FAIL rand_%0d: %h*%h got edge %0d cnt %0d %b/%h expected edge 16 cnt 1 %b/%h",
                 i, a, b, de, dc, Ovf, Result, (prod[31:16] != 16'h0), prod[15:0]);
      else pass_cnt++;
`ifdef MULT16_HI_RESULT_EN
      chk_cnt++; if (ResultHi !== prod[31:16]) $display("FAIL rand_hi_%0d: got %h expected %h", i, ResultHi, prod[31:16]); else pass_cnt++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [15:0] res [3];
    int          dedge [3];
    int          dc = 0;
    logic        busy17 = 1'b1;
    logic [31:0] prod;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom);
      res[i] = 'x; dedge[i] = -1;
    end
    @(negedge CLK); A = pa[0]; B = pb[0]; Start = 1'b1;
    for (int k = 0; k <= 56; k++) begin
      @(negedge CLK);
      if (k == 0)  begin A = pa[1]; B = pb[1]; end
      if (k == 18) begin A = pa[2]; B = pb[2]; end
      if (k == 36) begin Start = 1'b0; A = 16'($urandom); B = 16'($urandom); end
      if (k == 17) busy17 = Busy;
      if (Done) begin
        if (dc < 3) begin dedge[dc] = k; res[dc] = Result; end
        dc++;
      end
    end
    chk_cnt++; if (dc !== 3 || busy17 !== 1'b0) $display("FAIL b2b_count: got %0d busy17 %b expected 3 busy17 0", dc, busy17); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      prod = 32'(pa[i]) * 32'(pb[i]);
      chk_cnt++;
      if (dedge[i] !== 18*i + 16 || res[i] !== prod[15:0])
        $display("FAIL b2b_op%0d: got edge %0d result %h expected edge %0d result %h", i, dedge[i], res[i], 18*i + 16, prod[15:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_busy_ignore();
    test_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mult16_seq.md
Name: mult16_seq

Overview:
- Iterative shift-add unsigned multiplier for the 16-bit datapath.
- Sits directly upstream of a 16-bit datapath register. Result drives that register's I input; the one-cycle Done pulse drives its Write input.
- Replaces a large combinational multiplier with a fixed-latency, one-bit-per-cycle engine.

Parameters:
- WIDTH, 16, operand width and Result width. Internal product width is 2*WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request a multiply; sampled only in IDLE
- A  input  WIDTH  multiplicand, captured on the edge that accepts Start
- B  input  WIDTH  multiplier, captured on the edge that accepts Start
- Busy  output  1  high in RUN and DONE states
- Done  output  1  one-cycle pulse when Result is updated; downstream register Write
- Result  output  WIDTH  low WIDTH bits of A*B; holds value between operations
- Ovf  output  1  high when upper WIDTH bits of the product are nonzero; updated with Result

Behaviour:
- Reset (async, asserts immediately, independent of CLK):
  - state=IDLE; Busy=0, Done=0, Result=0, Ovf=0.
  - Iteration counter, accumulator and operand copies cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If Start=1 at a rising edge, latch A into a 2*WIDTH multiplicand register (zero-extended) and B into the multiplier register.
  - Clear the 2*WIDTH accumulator, load counter=WIDTH-1, go to RUN.
  - If Start=0, stay in IDLE.
- RUN, one step per edge:
  - If multiplier LSB=1, accumulator += multiplicand, computed modulo 2^(2*WIDTH); no carry out is possible.
  - Multiplicand shifts left 1; multiplier shifts right 1 (logical).
  - When counter=0 on that edge, go to DONE. Otherwise decrement the counter.
  - Exactly WIDTH RUN edges. There is no early termination when the multiplier becomes zero.
- Entry to DONE (same edge as the final RUN step):
  - Result <= accumulator[WIDTH-1:0], including the final step's addition.
  - Ovf <= |accumulator[2*WIDTH-1:WIDTH].
  - Done=1 for exactly the DONE cycle.
- DONE: the next edge always returns to IDLE; Done falls.
- Latency (accepting edge = edge 0):
  - Done high after edge WIDTH (edge 16 at default) and low after edge WIDTH+1.
  - Next Start can be accepted at edge WIDTH+2 at the earliest.
- Busy:
  - Rises after edge 0; falls after edge WIDTH+1.
  - Combinational decode of state; no glitch on the idle-to-idle path.
- Start while Busy=1 is ignored completely: no re-capture of A/B, no queueing.
- Start held high continuously produces back-to-back operations every WIDTH+2 cycles, each capturing A/B on its accepting edge.
- A and B may change freely after the accepting edge.
- Result and Ovf change only on entry to DONE or on Reset.
- Reset during RUN or DONE aborts the operation. No Done pulse follows; Result/Ovf return to 0.
- Zero operands: fixed latency still applies; Result=0, Ovf=0.

Optional Feature:
- Macro: MULT16_HI_RESULT_EN.
- Defined:
  - Extra port ResultHi, output, WIDTH bits, equal to accumulator[2*WIDTH-1:WIDTH].
  - ResultHi is registered alongside Result on entry to DONE; reset value 0; same hold and abort rules as Result.
- Not defined:
  - Port absent; upper product bits are used only to form Ovf.
  - Behaviour otherwise identical.

Test Plan:
- Reset: drive A=0x1234, B=0x0002, Start=1 for a full operation, then assert Reset between clock edges -> Busy, Done, Result, Ovf all 0 immediately without a clock edge; ResultHi=0 if enabled.
- Basic multiply: A=3, B=5, Start for one cycle at edge 0.
  - Busy=1 after edge 0; Done=1 only between edges 16 and 17.
  - Result=0x000F, Ovf=0; Busy=0 after edge 17.
- Overflow: A=0x0100, B=0x0100 -> Result=0x0000, Ovf=1, ResultHi=0x0001 (macro defined).
- Max operands: A=0xFFFF, B=0xFFFF -> Result=0x0001, Ovf=1, ResultHi=0xFFFE.
- Busy-ignore: start A=7, B=6; at edge 4 pulse Start with A=2, B=2 -> single Done pulse at edge 16, Result=0x002A; no second operation.
- Abort/recover: start A=9, B=9; assert Reset for 2 cycles at edge 8 -> no Done pulse, Result=0; then A=4, B=4, Start -> Result=0x0010 with Done 16 edges after acceptance.
